// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register,
// stall buffering, redirect draining and misaligned-PC (AdEL) injection.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_IF_next_pc,
  output logic [31:0] o_IF_current_pc,
  input  logic        i_redirect,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_ID_stall,
  output logic        o_ID_valid,
  output logic [31:0] o_ID_instr,
  output logic [31:0] o_ID_pc,
  output logic        o_ID_exc_adel
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN, S_EXC} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_adel_q, id_adel_d;
  logic        slot_free;
  logic        issue;

  assign slot_free = !id_valid_q || !i_ID_stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q && !i_imem_ack;
    addr_d      = addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    id_valid_d  = id_valid_q && i_ID_stall;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_adel_d   = id_adel_q;
    issue       = 1'b0;

    if (i_redirect) begin
      // An unacked request cannot be withdrawn; its response is swallowed in S_DRAIN.
      id_valid_d = 1'b0;
      pc_d       = i_IF_next_pc;
      state_d    = (req_q && !i_imem_ack) ? S_DRAIN : S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_q) begin
            if (i_imem_ack) begin
              if (slot_free) begin
                id_valid_d = 1'b1;
                id_instr_d = i_imem_rdata;
                id_pc_d    = addr_q;
                id_adel_d  = 1'b0;
                pc_d       = i_IF_next_pc;
                issue      = 1'b1;
              end else begin
                buf_instr_d = i_imem_rdata;
                buf_pc_d    = addr_q;
                state_d     = S_HOLD;
              end
            end
          end else if (slot_free) begin
            if (pc_q[1:0] != 2'b00) begin
              id_valid_d = 1'b1;
              id_instr_d = '0;
              id_pc_d    = pc_q;
              id_adel_d  = 1'b1;
              state_d    = S_EXC;
            end else begin
              issue = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            id_valid_d = 1'b1;
            id_instr_d = buf_instr_q;
            id_pc_d    = buf_pc_q;
            id_adel_d  = 1'b0;
            pc_d       = i_IF_next_pc;
            state_d    = S_REQ;
          end
        end
        S_DRAIN: begin
          if (i_imem_ack) state_d = S_REQ;
        end
        S_EXC: ;
        default: state_d = S_REQ;
      endcase

      // Request targets the PC value that will be architectural next cycle,
      // so an ack can be followed immediately by the next fetch.
      if (issue && (pc_d[1:0] == 2'b00)) begin
        req_d  = 1'b1;
        addr_d = pc_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      id_valid_q  <= 1'b0;
      id_instr_q  <= '0;
      id_pc_q     <= '0;
      id_adel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_adel_q   <= id_adel_d;
    end
  end

  assign o_IF_current_pc = pc_q;
  assign o_imem_req      = req_q;
  assign o_imem_addr     = addr_q;
  assign o_ID_valid      = id_valid_q;
  assign o_ID_instr      = id_instr_q;
  assign o_ID_pc         = id_pc_q;
  assign o_ID_exc_adel   = id_adel_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, a reset-mid-request sequence, and
// randomized fetch traffic checked against an architectural program-order model.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [31:0] i_IF_next_pc;
  logic [31:0] o_IF_current_pc;
  logic        i_redirect;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        i_ID_stall;
  logic        o_ID_valid;
  logic [31:0] o_ID_instr;
  logic [31:0] o_ID_pc;
  logic        o_ID_exc_adel;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .i_IF_next_pc   (i_IF_next_pc),
    .o_IF_current_pc(o_IF_current_pc),
    .i_redirect     (i_redirect),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_ack     (i_imem_ack),
    .i_imem_rdata   (i_imem_rdata),
    .i_ID_stall     (i_ID_stall),
    .o_ID_valid     (o_ID_valid),
    .o_ID_instr     (o_ID_instr),
    .o_ID_pc        (o_ID_pc),
    .o_ID_exc_adel  (o_ID_exc_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {reset, redirect, stall, ack}; eflg = {req before edge, valid after, adel after}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] npc;
    logic [31:0] rdat;
    logic [2:0]  eflg;
    logic [31:0] eaddr;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl [32];
  int   n_tot  = 0;
  int   n_pass = 0;
  int   n_cons = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [31:0] npc, input logic [31:0] rdat);
    {reset, i_redirect, i_ID_stall, i_imem_ack} = ctl;
    i_IF_next_pc = npc;
    i_imem_rdata = rdat;
  endtask

  a_req_stable: assert property (@(posedge clk) disable iff (reset)
    (o_imem_req && !i_imem_ack) |=> (o_imem_req && $stable(o_imem_addr)))
    else $error("FAIL req_stable: req=%b addr=%h", o_imem_req, o_imem_addr);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_next, held, tgt;
    logic        busy, stl, rdr, ack;
    int unsigned lat;

    tbl = '{
      '{4'b1000, 32'h000, 32'h0,         3'b000, 32'h000, 32'h0,         32'h000, 32'h000},
      '{4'b0000, 32'h004, 32'h0,         3'b000, 32'h000, 32'h0,         32'h000, 32'h000},
      '{4'b0001, 32'h004, 32'hC0DE0000,  3'b110, 32'h000, 32'hC0DE0000,  32'h000, 32'h004},
      '{4'b0001, 32'h008, 32'hC0DE0004,  3'b110, 32'h004, 32'hC0DE0004,  32'h004, 32'h008},
      '{4'b0001, 32'h00C, 32'hC0DE0008,  3'b110, 32'h008, 32'hC0DE0008,  32'h008, 32'h00C},
      '{4'b0010, 32'h010, 32'h0,         3'b110, 32'h00C, 32'hC0DE0008,  32'h008, 32'h00C},
      '{4'b0010, 32'h010, 32'h0,         3'b110, 32'h00C, 32'hC0DE0008,  32'h008, 32'h00C},
      '{4'b0011, 32'h010, 32'hC0DE000C,  3'b110, 32'h00C, 32'hC0DE0008,  32'h008, 32'h00C},
      '{4'b0010, 32'h010, 32'h0,         3'b010, 32'h00C, 32'hC0DE0008,  32'h008, 32'h00C},
      '{4'b0000, 32'h010, 32'h0,         3'b010, 32'h00C, 32'hC0DE000C,  32'h00C, 32'h010},
      '{4'b0000, 32'h014, 32'h0,         3'b000, 32'h00C, 32'h0,         32'h000, 32'h010},
      '{4'b0100, 32'h040, 32'h0,         3'b100, 32'h010, 32'h0,         32'h000, 32'h040},
      '{4'b0000, 32'h044, 32'h0,         3'b100, 32'h010, 32'h0,         32'h000, 32'h040},
      '{4'b0001, 32'h044, 32'hC0DE0010,  3'b100, 32'h010, 32'h0,         32'h000, 32'h040},
      '{4'b0000, 32'h044, 32'h0,         3'b000, 32'h010, 32'h0,         32'h000, 32'h040},
      '{4'b0001, 32'h044, 32'hC0DE0040,  3'b110, 32'h040, 32'hC0DE0040,  32'h040, 32'h044},
      '{4'b0001, 32'h022, 32'hC0DE0044,  3'b110, 32'h044, 32'hC0DE0044,  32'h044, 32'h022},
      '{4'b0000, 32'h026, 32'h0,         3'b011, 32'h044, 32'h0,         32'h022, 32'h022},
      '{4'b0000, 32'h026, 32'h0,         3'b000, 32'h044, 32'h0,         32'h000, 32'h022},
      '{4'b0000, 32'h026, 32'h0,         3'b000, 32'h044, 32'h0,         32'h000, 32'h022},
      '{4'b0100, 32'h040, 32'h0,         3'b000, 32'h044, 32'h0,         32'h000, 32'h040},
      '{4'b0000, 32'h044, 32'h0,         3'b000, 32'h044, 32'h0,         32'h000, 32'h040},
      '{4'b0000, 32'h044, 32'h0,         3'b100, 32'h040, 32'h0,         32'h000, 32'h040},
      '{4'b0001, 32'h044, 32'hC0DE0040,  3'b110, 32'h040, 32'hC0DE0040,  32'h040, 32'h044},
      '{4'b0111, 32'h080, 32'hC0DE0044,  3'b100, 32'h044, 32'h0,         32'h000, 32'h080},
      '{4'b0000, 32'h084, 32'h0,         3'b000, 32'h044, 32'h0,         32'h000, 32'h080},
      '{4'b0001, 32'h084, 32'hC0DE0080,  3'b110, 32'h080, 32'hC0DE0080,  32'h080, 32'h084},
      '{4'b0100, 32'h100, 32'h0,         3'b100, 32'h084, 32'h0,         32'h000, 32'h100},
      '{4'b0100, 32'h200, 32'h0,         3'b100, 32'h084, 32'h0,         32'h000, 32'h200},
      '{4'b0001, 32'h204, 32'hC0DE0084,  3'b100, 32'h084, 32'h0,         32'h000, 32'h200},
      '{4'b0000, 32'h204, 32'h0,         3'b000, 32'h084, 32'h0,         32'h000, 32'h200},
      '{4'b0001, 32'h204, 32'hC0DE0200,  3'b110, 32'h200, 32'hC0DE0200,  32'h200, 32'h204}
    };

    drive(4'b1000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(tbl[i].ctl, tbl[i].npc, tbl[i].rdat);
      #1;
      chk($sformatf("t%0d_req", i), {31'd0, o_imem_req}, {31'd0, tbl[i].eflg[2]});
      chk($sformatf("t%0d_addr", i), o_imem_addr, tbl[i].eaddr);
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_valid", i), {31'd0, o_ID_valid}, {31'd0, tbl[i].eflg[1]});
      chk($sformatf("t%0d_pc", i), o_IF_current_pc, tbl[i].epc);
      if (tbl[i].eflg[1] || tbl[i].ctl[3]) begin
        chk($sformatf("t%0d_instr", i), o_ID_instr, tbl[i].ei);
        chk($sformatf("t%0d_idpc", i), o_ID_pc, tbl[i].ep);
        chk($sformatf("t%0d_adel", i), {31'd0, o_ID_exc_adel}, {31'd0, tbl[i].eflg[0]});
      end
    end

    // Reset while a request is outstanding: abandoned, then a fresh fetch from 0.
    @(negedge clk);
    drive(4'b0000, o_IF_current_pc + 32'd4, 32'h0);
    #1 chk("mid_req_pending", {31'd0, o_imem_req}, 32'd1);
    @(negedge clk);
    drive(4'b1000, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_req", {31'd0, o_imem_req}, 32'd0);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_pc", o_IF_current_pc, 32'h0);
    chk("rst_valid", {31'd0, o_ID_valid}, 32'd0);
    @(negedge clk);
    drive(4'b0000, 32'h4, 32'h0);
    #1 chk("post_rst_idle", {31'd0, o_imem_req}, 32'd0);
    @(negedge clk);
    drive(4'b0000, 32'h4, 32'h0);
    #1;
    chk("post_rst_req", {31'd0, o_imem_req}, 32'd1);
    chk("post_rst_addr", o_imem_addr, 32'h0);

    // Randomized traffic; ID must see words in program order, restarting at each redirect target.
    @(negedge clk);
    drive(4'b1000, 32'h0, 32'h0);
    @(posedge clk);
    busy     = 1'b0;
    held     = '0;
    lat      = 0;
    exp_next = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      stl = ($urandom % 100) < 30;
      rdr = ($urandom % 100) < 6;
      tgt = $urandom_range(255, 0) << 2;
      if (busy) begin
        chk("rnd_req_held", {31'd0, o_imem_req}, 32'd1);
        chk("rnd_addr_held", o_imem_addr, held);
      end
      if (o_imem_req && !busy) begin
        busy = 1'b1;
        held = o_imem_addr;
        lat  = $urandom_range(3, 0);
      end
      ack = busy && (lat == 0);
      drive({1'b0, rdr, stl, ack}, rdr ? tgt : o_IF_current_pc + 32'd4,
            ack ? memf(held) : $urandom);
      #1;
      if (o_ID_valid && !stl) begin
        n_cons++;
        chk("rnd_id_pc", o_ID_pc, exp_next);
        chk("rnd_id_instr", o_ID_instr, memf(exp_next));
        chk("rnd_id_adel", {31'd0, o_ID_exc_adel}, 32'd0);
        exp_next = exp_next + 32'd4;
      end
      if (rdr) exp_next = tgt;
      @(posedge clk);
      if (ack) busy = 1'b0;
      else if (busy) lat = lat - 1;
    end
    chk("rnd_progress", {31'd0, (n_cons >= 150)}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: i_IF_next_pc  input  32  next PC from the next-PC selector (pc+4, branch target, eret EPC or exception vector).
REQ-004 SHALL: o_IF_current_pc  output  32  architectural fetch PC, fed back to the next-PC selector.
REQ-005 SHALL: i_redirect  input  1  non-sequential PC change (branch/jump, eret, exception); kills all fetch work younger than the redirect.
REQ-006 SHALL: o_imem_req  output  1, o_imem_addr  output  32  instruction memory request and word address.
REQ-007 SHALL: i_imem_ack  input  1, i_imem_rdata  input  32  memory acknowledge (same cycle as req or later) and instruction word.
REQ-008 SHALL: i_ID_stall  input  1  ID cannot consume the IF/ID register this cycle.
REQ-009 SHALL: o_ID_valid  output  1, o_ID_instr  output  32, o_ID_pc  output  32, o_ID_exc_adel  output  1  IF/ID pipeline register contents.

Function
REQ-010 SHALL: FSM states S_REQ, S_HOLD, S_DRAIN, S_EXC; no branch delay slot.
REQ-011 SHALL: "slot free" = !o_ID_valid || !i_ID_stall.
REQ-012 SHALL: S_REQ, pc[1:0]==0, slot free, no redirect -> raise o_imem_req with o_imem_addr=pc, latched into a request-address register.
REQ-013 SHALL: once o_imem_req is high, it and o_imem_addr stay constant until the cycle i_imem_ack=1; req drops the cycle after ack unless a new request is issued.
REQ-014 SHALL: ack in S_REQ with slot free -> IF/ID <= {valid=1, i_imem_rdata, request address, adel=0}; pc <= i_IF_next_pc; zero-bubble back-to-back fetch permitted.
REQ-015 SHALL: ack in S_REQ with slot not free -> buffer rdata/address internally, go S_HOLD, pc unchanged.
REQ-016 SHALL: S_HOLD with slot free -> load buffer into IF/ID, pc <= i_IF_next_pc, go S_REQ; no memory request while in S_HOLD.
REQ-017 SHALL: S_REQ, pc[1:0]!=0, slot free -> no memory request; IF/ID <= {valid=1, instr=0x00000000, pc, adel=1}; go S_EXC.
REQ-018 SHALL: S_EXC holds pc and issues no requests until i_redirect.
REQ-019 SHALL: i_redirect, any state, takes priority over stall and ack: o_ID_valid <= 0, pc <= i_IF_next_pc, buffered/acked data discarded.
REQ-020 SHALL: i_redirect while a request is outstanding and not acked that cycle -> go S_DRAIN; req/addr held until ack; acked data discarded; then S_REQ.
REQ-021 SHALL: further i_redirect during S_DRAIN -> pc <= i_IF_next_pc, remain S_DRAIN.
REQ-022 SHALL: redirect in S_REQ with ack in the same cycle -> data discarded, stay S_REQ, new pc fetched next cycle.
REQ-023 SHALL: no load and !i_ID_stall -> o_ID_valid <= 0; i_ID_stall with o_ID_valid=1 -> all IF/ID fields hold.
REQ-024 SHALL: o_IF_current_pc is the pc register (registered, not i_IF_next_pc); PC width 32 bits, wrap-around from 0xfffffffc to 0x00000000 is not special-cased.

Reset
REQ-025 SHALL: reset -> pc=0x00000000, state S_REQ, o_imem_req=0, o_imem_addr=0, o_ID_valid=0, o_ID_instr=0, o_ID_pc=0, o_ID_exc_adel=0, buffers cleared.
REQ-026 SHALL: reset mid-request abandons the outstanding request with no drain; the memory model is reset in the same cycle.
REQ-027 SHALL: first o_imem_req asserted the cycle after reset deasserts, with addr 0x00000000.

Verification
REQ-028 SHALL: reset; ack same cycle as req, next_pc=pc+4 -> IF/ID gets pc 0x0,0x4,0x8 on consecutive cycles, valid continuously 1.
REQ-029 SHALL: ack 3 cycles late, i_ID_stall=1 at ack -> S_HOLD, req low; stall released -> IF/ID loads held word, pc advances by 4 exactly once.
REQ-030 SHALL: redirect to 0x00000040 while req to 0x10 outstanding, ack 2 cycles later -> 0x10 data never reaches IF/ID; next req addr 0x00000040.
REQ-031 SHALL: next_pc=0x00000022 loaded -> no req; IF/ID {valid=1, instr=0, pc=0x22, adel=1}; pc frozen until redirect to 0x40, then req addr 0x40.
REQ-032 SHALL: redirect, i_ID_stall and ack all in one cycle -> o_ID_valid=0 next cycle, pc=i_IF_next_pc, acked word dropped.
REQ-033 SHALL: assertion bench-wide: o_imem_addr stable and o_imem_req high from req rise until ack.
